multicycle_cpu: RTL and testbench
=================================

# multicycle_cpu

Parametrised multicycle RV32I-subset core: the successor to our single-cycle CPU top. One FSM sequences fetch, decode, execute, memory and writeback over a single shared memory port with a ready handshake, so instruction and data memories may have wait states. It exposes register a0 (x10) for the testbench and display logic, like the single-cycle top, and adds halt and retire status.

## Interface
- DATA_WIDTH, 32: register/ALU width; supported values 32 and 64.
- ADDR_WIDTH, 32: memory address width; PC width.
- RESET_PC, 0: PC value loaded at reset.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-low.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = store, 0 = read; valid while mem_req.
- mem_addr  out  ADDR_WIDTH  byte address, word-aligned.
- mem_wdata  out  DATA_WIDTH  store data.
- mem_rdata  in  DATA_WIDTH  read data; sampled in the mem_ready cycle.
- mem_ready  in  1  transaction completes in a cycle with mem_req && mem_ready.
- a0  out  DATA_WIDTH  current value of x10.
- retire  out  1  one-cycle pulse per completed instruction.
- halt  out  1  high, sticky until reset, after an illegal opcode.
- cycle_cnt, instret_cnt  out  DATA_WIDTH  performance counters (see Configuration).

## Operation
- Supported: add, sub, and, or, slt (R); addi (I); lw; sw; beq, bne; jal; lui. Any other op[6:0] is illegal.
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT.
- FETCH: mem_req=1, mem_we=0, mem_addr=PC. Stay until mem_ready; then latch IR, old_pc=PC, PC<=PC+4 (wraps modulo 2^ADDR_WIDTH), go to DECODE.
- DECODE: read rs1/rs2 into A/B; compute branch/jal target old_pc+imm; illegal opcode -> HALT.
- EXECUTE: ALU op into ALUOut. beq/bne: PC<=target if taken, retire, go to FETCH. lw/sw -> MEMORY. Others -> WRITEBACK.
- MEMORY: mem_req=1, mem_addr=ALUOut, mem_we=1 for sw (mem_wdata=B). Stay until mem_ready. sw: retire, go to FETCH. lw: latch mem_rdata into MDR, go to WRITEBACK.
- WRITEBACK: rd<=ALUOut, MDR (lw), old_pc+4 (jal; PC<=target), or imm (lui); retire; go to FETCH.
- x0 reads 0; writes to x0 discarded.
- Immediates sign-extended to DATA_WIDTH; slt is signed; add/sub wrap.
- HALT: mem_req=0, no register or PC writes; leave only via reset.
- mem_req never drops before mem_ready; address/we/wdata stable throughout a request.

## Timing
- Reset (rst low at edge): state=FETCH, PC=RESET_PC, all registers 0, a0=0, retire=0, halt=0, counters 0. mem_req is high in the first cycle after reset. A transaction in flight when reset hits is abandoned.
- Zero-wait memory (mem_ready always 1): branch 3 cycles, sw 4, ALU/jal/lui 4, lw 5. Each mem_ready-low cycle adds one cycle.
- retire is asserted in the last cycle of the instruction; the write to rd and PC is visible the next cycle; a0 reflects an x10 write the cycle after WRITEBACK.
- halt is high from the cycle after DECODE of the illegal instruction.

## Configuration
- MULTICYCLE_PERFCNT_EN defined: cycle_cnt increments every cycle out of reset (including HALT); instret_cnt increments on each retire; both wrap at 2^DATA_WIDTH.
- Not defined: counter flops absent; cycle_cnt and instret_cnt tied to 0. Ports always exist.

## Structure
- Shared package cpu_pkg: state enum, opcode constants (R, I, LOAD, STORE, BRANCH, JAL, LUI), ALU control enum, immediate-type enum.
- Sub-module reg_file: 32 x DATA_WIDTH, two async read ports, one sync write port, x0 hardwired, a0 tap, synchronous active-low clear. ALU and immediate generation stay inline.

## Test plan
- addi x10,x0,5 then add x10,x10,x10 at RESET_PC=0, mem_ready=1 -> a0=10; retire pulses at cycles 4 and 8; mem_addr in FETCH 0 then 4.
- sw x10,8(x0) then lw x11,8(x0) with mem_ready low for 3 cycles on each access -> write of 10 to addr 8 held stable 4 cycles; x11=10; lw takes 8 cycles.
- beq x0,x0,-8 at PC 0x10 -> next fetch address 0x08; bne x0,x0 not taken -> 0x14; each 3 cycles.
- jal x1,16 at PC 0x20 -> x1=0x24, next fetch 0x30; lui x10,0x12345 -> a0=0x12345000.
- Opcode 0x7F fetched -> halt=1, mem_req=0 permanently; rst low one cycle -> halt=0, fetch from RESET_PC.
- rst low in MEMORY mid-stall -> no store completes, state FETCH, PC=RESET_PC; with MULTICYCLE_PERFCNT_EN, after 10 zero-wait addi, instret_cnt=10 and cycle_cnt=40.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the multicycle RV32I-subset core.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_HALT
    } state_t;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_LUI    = 7'h37;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_ctrl_t;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_t;

endpackage

// File: rtl/reg_file.sv
// 32-entry register file: two async read ports, one sync write port, x0 fixed at zero.
module reg_file #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic [4:0]            i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [4:0]            i_raddr1,
    input  logic [4:0]            i_raddr2,
    output logic [DATA_WIDTH-1:0] o_rdata1,
    output logic [DATA_WIDTH-1:0] o_rdata2,
    output logic [DATA_WIDTH-1:0] o_a0
);

    logic [DATA_WIDTH-1:0] r_regs [0:31];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == 5'd0) ? '0 : r_regs[i_raddr1];
    assign o_rdata2 = (i_raddr2 == 5'd0) ? '0 : r_regs[i_raddr2];
    assign o_a0     = r_regs[10];

endmodule

// File: rtl/multicycle_cpu.sv
// Multicycle RV32I-subset core sharing one memory port between fetch and load/store.
// Optional performance counters are built when MULTICYCLE_PERFCNT_EN is defined.
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic [DATA_WIDTH-1:0] a0,
    output logic                  retire,
    output logic                  halt,
    output logic [DATA_WIDTH-1:0] cycle_cnt,
    output logic [DATA_WIDTH-1:0] instret_cnt
);

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_pc, r_old_pc, r_target;
    logic [31:0]           r_ir;
    logic [DATA_WIDTH-1:0] r_a, r_b, r_aluout, r_mdr;

    logic [6:0]            w_opcode;
    logic                  w_legal, w_taken, w_retire, w_rf_we;
    imm_type_t             w_imm_type;
    logic [31:0]           w_imm32;
    logic [DATA_WIDTH-1:0] w_imm, w_alu_b, w_alu_res, w_rf_wdata, w_rs1_val, w_rs2_val;
    alu_ctrl_t             w_alu_ctrl;

    assign w_opcode = r_ir[6:0];
    assign w_legal  = w_opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI};
    assign w_taken  = r_ir[12] ? (r_a != r_b) : (r_a == r_b);

    always_comb begin
        case (w_opcode)
            OP_STORE:  w_imm_type = IMM_S;
            OP_BRANCH: w_imm_type = IMM_B;
            OP_JAL:    w_imm_type = IMM_J;
            OP_LUI:    w_imm_type = IMM_U;
            default:   w_imm_type = IMM_I;
        endcase
        case (w_imm_type)
            IMM_S:   w_imm32 = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
            IMM_B:   w_imm32 = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
            IMM_J:   w_imm32 = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
            IMM_U:   w_imm32 = {r_ir[31:12], 12'b0};
            default: w_imm32 = {{20{r_ir[31]}}, r_ir[31:20]};
        endcase
    end

    assign w_imm = DATA_WIDTH'(signed'(w_imm32));

    always_comb begin
        w_alu_ctrl = ALU_ADD;
        if (w_opcode == OP_R) begin
            case (r_ir[14:12])
                3'b000:  w_alu_ctrl = r_ir[30] ? ALU_SUB : ALU_ADD;
                3'b111:  w_alu_ctrl = ALU_AND;
                3'b110:  w_alu_ctrl = ALU_OR;
                3'b010:  w_alu_ctrl = ALU_SLT;
                default: w_alu_ctrl = ALU_ADD;
            endcase
        end
    end

    assign w_alu_b = (w_opcode == OP_R) ? r_b : w_imm;

    always_comb begin
        case (w_alu_ctrl)
            ALU_SUB: w_alu_res = r_a - w_alu_b;
            ALU_AND: w_alu_res = r_a & w_alu_b;
            ALU_OR:  w_alu_res = r_a | w_alu_b;
            ALU_SLT: w_alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(r_a) < $signed(w_alu_b))};
            default: w_alu_res = r_a + w_alu_b;
        endcase
    end

    // r_pc already holds old_pc+4 by writeback, so it doubles as the jal link value.
    always_comb begin
        case (w_opcode)
            OP_LOAD: w_rf_wdata = r_mdr;
            OP_JAL:  w_rf_wdata = DATA_WIDTH'(r_pc);
            OP_LUI:  w_rf_wdata = w_imm;
            default: w_rf_wdata = r_aluout;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_FETCH;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = r_pc;
        w_retire  = 1'b0;
        w_rf_we   = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: w_next = w_legal ? S_EXECUTE : S_HALT;
            S_EXECUTE: begin
                if (w_opcode == OP_BRANCH) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else if ((w_opcode == OP_LOAD) || (w_opcode == OP_STORE)) begin
                    w_next = S_MEMORY;
                end else begin
                    w_next = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                mem_req  = 1'b1;
                mem_we   = (w_opcode == OP_STORE);
                mem_addr = ADDR_WIDTH'(r_aluout);
                if (mem_ready) begin
                    w_retire = (w_opcode == OP_STORE);
                    w_next   = (w_opcode == OP_STORE) ? S_FETCH : S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                w_rf_we  = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc     <= RESET_PC;
            r_old_pc <= '0;
            r_target <= '0;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
            r_mdr    <= '0;
        end else begin
            case (r_state)
                S_FETCH: if (mem_ready) begin
                    r_ir     <= mem_rdata[31:0];
                    r_old_pc <= r_pc;
                    r_pc     <= r_pc + ADDR_WIDTH'(4);
                end
                S_DECODE: begin
                    r_a      <= w_rs1_val;
                    r_b      <= w_rs2_val;
                    r_target <= r_old_pc + ADDR_WIDTH'(signed'(w_imm32));
                end
                S_EXECUTE: begin
                    r_aluout <= w_alu_res;
                    if ((w_opcode == OP_BRANCH) && w_taken) r_pc <= r_target;
                end
                S_MEMORY:    if (mem_ready && (w_opcode == OP_LOAD)) r_mdr <= mem_rdata;
                S_WRITEBACK: if (w_opcode == OP_JAL) r_pc <= r_target;
                default: ;
            endcase
        end
    end

    reg_file #(.DATA_WIDTH(DATA_WIDTH)) u_reg_file (
        .i_clk    (clk),
        .i_rst_n  (rst),
        .i_we     (w_rf_we),
        .i_waddr  (r_ir[11:7]),
        .i_wdata  (w_rf_wdata),
        .i_raddr1 (r_ir[19:15]),
        .i_raddr2 (r_ir[24:20]),
        .o_rdata1 (w_rs1_val),
        .o_rdata2 (w_rs2_val),
        .o_a0     (a0)
    );

    assign mem_wdata = r_b;
    assign retire    = w_retire;
    assign halt      = (r_state == S_HALT);

`ifdef MULTICYCLE_PERFCNT_EN
    logic [DATA_WIDTH-1:0] r_cycle_cnt, r_instret_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + DATA_WIDTH'(1);
            if (w_retire) r_instret_cnt <= r_instret_cnt + DATA_WIDTH'(1);
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed self-checking bench for multicycle_cpu with a wait-state memory model.
`timescale 1ns/1ps
module tb_multicycle_cpu;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mem_req, mem_we, mem_ready, retire, halt;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata, a0, cycle_cnt, instret_cnt;

    always #5 clk = ~clk;

    multicycle_cpu #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .a0          (a0),
        .retire      (retire),
        .halt        (halt),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    // Memory model: program image reloaded while reset is low; accesses to stall_addr wait stall_n cycles.
    logic [31:0]   mem  [0:63];
    logic [31:0]   prog [0:63];
    logic [AW-1:0] stall_addr = 32'hFFFF_FFFC;
    int            stall_n    = 0;
    logic [7:0]    wcnt       = 8'd0;
    int            store_cnt  = 0;

    assign mem_rdata = mem[mem_addr[7:2]];
    assign mem_ready = mem_req && ((mem_addr != stall_addr) || (int'(wcnt) >= stall_n));

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) mem[i] = prog[i];
            wcnt <= 8'd0;
        end else begin
            if (mem_req && mem_ready && mem_we) begin
                mem[mem_addr[7:2]] = mem_wdata;
                store_cnt = store_cnt + 1;
            end
            if (mem_req && !mem_ready) wcnt <= wcnt + 8'd1;
            else                       wcnt <= 8'd0;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 1;

    logic        tr_retire [0:127];
    logic        tr_req    [0:127];
    logic        tr_we     [0:127];
    logic        tr_halt   [0:127];
    logic [31:0] tr_addr   [0:127];
    logic [31:0] tr_wdata  [0:127];
    logic [31:0] tr_a0     [0:127];

    function automatic logic [31:0] enc_r(input logic f7b5, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd);
        logic [31:0] s2, s1, d;
        s2 = rs2; s1 = rs1; d = rd;
        return {1'b0, f7b5, 5'b0, s2[4:0], s1[4:0], f3, d[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                          input int rd, input logic [6:0] op);
        logic [31:0] v, s1, d;
        v = imm; s1 = rs1; d = rd;
        return {v[11:0], s1[4:0], f3, d[4:0], op};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [31:0] v, s2, s1;
        v = imm; s2 = rs2; s1 = rs1;
        return {v[11:5], s2[4:0], s1[4:0], 3'b010, v[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input logic [2:0] f3);
        logic [31:0] v, s2, s1;
        v = imm; s2 = rs2; s1 = rs1;
        return {v[12], v[10:5], s2[4:0], s1[4:0], f3, v[4:1], v[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] v, d;
        v = imm; d = rd;
        return {v[20], v[10:1], v[11], v[19:12], d[4:0], 7'h6F};
    endfunction

    function automatic logic [31:0] enc_u(input int imm20, input int rd);
        logic [31:0] v, d;
        v = imm20; d = rd;
        return {v[19:0], d[4:0], 7'h37};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) prog[i] = 32'h0000_007F;
        stall_addr = 32'hFFFF_FFFC;
        stall_n    = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        cyc = 1;
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            tr_retire[cyc] = retire;
            tr_req[cyc]    = mem_req;
            tr_we[cyc]     = mem_we;
            tr_halt[cyc]   = halt;
            tr_addr[cyc]   = mem_addr;
            tr_wdata[cyc]  = mem_wdata;
            tr_a0[cyc]     = a0;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        clear_prog();
        prog[0] = enc_i(1, 0, 3'b000, 10, 7'h13);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 1;
        n_chk++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL reset_mem_req: got %b expected 1", mem_req); end
        n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        n_chk++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        n_chk++; if (retire !== 1'b0 || halt !== 1'b0) begin n_fail++; $display("FAIL reset_status: got retire=%b halt=%b expected 0 0", retire, halt); end
        n_chk++; if (a0 !== 32'h0) begin n_fail++; $display("FAIL reset_a0: got %h expected 0", a0); end
        n_chk++; if (cycle_cnt !== 32'h0 || instret_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_counters: got %0d %0d expected 0 0", cycle_cnt, instret_cnt); end
    endtask

    task automatic test_alu_add();
        clear_prog();
        prog[0] = enc_i(5, 0, 3'b000, 10, 7'h13);
        prog[1] = enc_r(1'b0, 10, 10, 3'b000, 10);
        do_reset();
        run_cycles(9);
        for (int c = 1; c <= 8; c++) begin
            n_chk++;
            if (tr_retire[c] !== ((c == 4) || (c == 8))) begin
                n_fail++; $display("FAIL add_retire_c%0d: got %b expected %b", c, tr_retire[c], (c == 4) || (c == 8));
            end
        end
        n_chk++; if (tr_req[1] !== 1'b1 || tr_addr[1] !== 32'h0) begin n_fail++; $display("FAIL add_fetch0: got req=%b addr=%h expected 1 0", tr_req[1], tr_addr[1]); end
        n_chk++; if (tr_req[5] !== 1'b1 || tr_addr[5] !== 32'h4) begin n_fail++; $display("FAIL add_fetch1: got req=%b addr=%h expected 1 4", tr_req[5], tr_addr[5]); end
        n_chk++; if (tr_a0[5] !== 32'd5) begin n_fail++; $display("FAIL add_addi_a0: got %h expected 5", tr_a0[5]); end
        n_chk++; if (tr_a0[9] !== 32'd10) begin n_fail++; $display("FAIL add_a0: got %h expected 10", tr_a0[9]); end
    endtask

    task automatic test_alu_ops();
        int          idx   [0:5];
        logic [31:0] exp_v [0:5];
        clear_prog();
        prog[0] = enc_i(-3, 0, 3'b000, 5, 7'h13);
        prog[1] = enc_i(5, 0, 3'b000, 6, 7'h13);
        prog[2] = enc_r(1'b1, 6, 5, 3'b000, 10);
        prog[3] = enc_r(1'b0, 6, 5, 3'b111, 10);
        prog[4] = enc_r(1'b0, 6, 5, 3'b110, 10);
        prog[5] = enc_r(1'b0, 6, 5, 3'b010, 10);
        prog[6] = enc_r(1'b0, 5, 6, 3'b010, 10);
        prog[7] = enc_i(9, 0, 3'b000, 0, 7'h13);
        prog[8] = enc_r(1'b0, 5, 0, 3'b000, 10);
        idx[0] = 13; exp_v[0] = 32'hFFFF_FFF8;
        idx[1] = 17; exp_v[1] = 32'h0000_0005;
        idx[2] = 21; exp_v[2] = 32'hFFFF_FFFD;
        idx[3] = 25; exp_v[3] = 32'h0000_0001;
        idx[4] = 29; exp_v[4] = 32'h0000_0000;
        idx[5] = 37; exp_v[5] = 32'hFFFF_FFFD;
        do_reset();
        run_cycles(37);
        for (int k = 0; k < 6; k++) begin
            n_chk++;
            if (tr_a0[idx[k]] !== exp_v[k]) begin
                n_fail++; $display("FAIL aluops_%0d: got %h expected %h", k, tr_a0[idx[k]], exp_v[k]);
            end
        end
    endtask

    task automatic test_mem_stall();
        int s0, n_st, n_bad, n_ret, first_st;
        clear_prog();
        prog[0]  = enc_j(64, 0);
        prog[2]  = 32'hDEAD_0000;
        prog[16] = enc_i(10, 0, 3'b000, 10, 7'h13);
        prog[17] = enc_s(8, 10, 0);
        prog[18] = enc_i(8, 0, 3'b010, 11, 7'h03);
        prog[19] = enc_i(1, 11, 3'b000, 10, 7'h13);
        stall_addr = 32'h8;
        stall_n    = 3;
        do_reset();
        s0 = store_cnt;
        run_cycles(28);
        n_st = 0; n_bad = 0; n_ret = 0; first_st = 0;
        for (int c = 1; c <= 28; c++) begin
            if (tr_req[c] && tr_we[c]) begin
                n_st++;
                if (first_st == 0) first_st = c;
                if (tr_addr[c] !== 32'h8 || tr_wdata[c] !== 32'd10) n_bad++;
            end
            if (c >= 16 && c <= 22 && tr_retire[c]) n_ret++;
        end
        n_chk++; if (n_st != 4 || first_st != 12) begin n_fail++; $display("FAIL sw_hold: got %0d cycles from %0d expected 4 from 12", n_st, first_st); end
        n_chk++; if (n_bad != 0) begin n_fail++; $display("FAIL sw_stable: got %0d unstable cycles expected 0", n_bad); end
        n_chk++; if (store_cnt - s0 != 1) begin n_fail++; $display("FAIL sw_count: got %0d stores expected 1", store_cnt - s0); end
        n_chk++; if (mem[2] !== 32'd10) begin n_fail++; $display("FAIL sw_data: got %h expected 0000000a", mem[2]); end
        n_chk++; if (tr_retire[15] !== 1'b1) begin n_fail++; $display("FAIL sw_retire: got %b expected 1", tr_retire[15]); end
        n_chk++; if (tr_retire[23] !== 1'b1 || n_ret != 0) begin n_fail++; $display("FAIL lw_latency: got retire23=%b early=%0d expected 1 0", tr_retire[23], n_ret); end
        n_chk++; if (tr_a0[28] !== 32'd11) begin n_fail++; $display("FAIL lw_value: got %h expected 0000000b", tr_a0[28]); end
    endtask

    task automatic test_branch();
        clear_prog();
        prog[0] = enc_j(16, 0);
        prog[4] = enc_b(-8, 0, 0, 3'b000);
        prog[2] = enc_i(3, 0, 3'b000, 10, 7'h13);
        do_reset();
        run_cycles(12);
        n_chk++; if (tr_addr[5] !== 32'h10) begin n_fail++; $display("FAIL beq_fetch: got %h expected 10", tr_addr[5]); end
        n_chk++; if (tr_retire[7] !== 1'b1 || tr_retire[6] !== 1'b0) begin n_fail++; $display("FAIL beq_retire: got c6=%b c7=%b expected 0 1", tr_retire[6], tr_retire[7]); end
        n_chk++; if (tr_req[8] !== 1'b1 || tr_addr[8] !== 32'h8) begin n_fail++; $display("FAIL beq_target: got %h expected 8", tr_addr[8]); end
        n_chk++; if (tr_a0[12] !== 32'd3) begin n_fail++; $display("FAIL beq_a0: got %h expected 3", tr_a0[12]); end

        clear_prog();
        prog[0] = enc_j(16, 0);
        prog[4] = enc_b(-8, 0, 0, 3'b001);
        prog[5] = enc_i(4, 0, 3'b000, 10, 7'h13);
        do_reset();
        run_cycles(12);
        n_chk++; if (tr_retire[7] !== 1'b1) begin n_fail++; $display("FAIL bne_retire: got %b expected 1", tr_retire[7]); end
        n_chk++; if (tr_req[8] !== 1'b1 || tr_addr[8] !== 32'h14) begin n_fail++; $display("FAIL bne_next: got %h expected 14", tr_addr[8]); end
        n_chk++; if (tr_a0[12] !== 32'd4) begin n_fail++; $display("FAIL bne_a0: got %h expected 4", tr_a0[12]); end
    endtask

    task automatic test_jal_lui();
        clear_prog();
        prog[0]  = enc_j(32, 0);
        prog[8]  = enc_j(16, 1);
        prog[12] = enc_i(0, 1, 3'b000, 10, 7'h13);
        prog[13] = enc_u(32'h12345, 10);
        do_reset();
        run_cycles(17);
        n_chk++; if (tr_addr[5] !== 32'h20) begin n_fail++; $display("FAIL jal_fetch: got %h expected 20", tr_addr[5]); end
        n_chk++; if (tr_retire[8] !== 1'b1 || tr_retire[7] !== 1'b0) begin n_fail++; $display("FAIL jal_retire: got c7=%b c8=%b expected 0 1", tr_retire[7], tr_retire[8]); end
        n_chk++; if (tr_addr[9] !== 32'h30) begin n_fail++; $display("FAIL jal_target: got %h expected 30", tr_addr[9]); end
        n_chk++; if (tr_a0[13] !== 32'h24) begin n_fail++; $display("FAIL jal_link: got %h expected 24", tr_a0[13]); end
        n_chk++; if (tr_a0[17] !== 32'h1234_5000) begin n_fail++; $display("FAIL lui_a0: got %h expected 12345000", tr_a0[17]); end
    endtask

    task automatic test_halt();
        int n_bad;
        clear_prog();
        prog[0] = 32'h0000_007F;
        do_reset();
        run_cycles(12);
        n_bad = 0;
        for (int c = 3; c <= 12; c++)
            if (tr_halt[c] !== 1'b1 || tr_req[c] !== 1'b0 || tr_retire[c] !== 1'b0) n_bad++;
        n_chk++; if (tr_halt[2] !== 1'b0) begin n_fail++; $display("FAIL halt_early: got %b expected 0", tr_halt[2]); end
        n_chk++; if (n_bad != 0) begin n_fail++; $display("FAIL halt_sticky: got %0d bad cycles expected 0", n_bad); end
        do_reset();
        n_chk++; if (halt !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            n_fail++; $display("FAIL halt_clear: got halt=%b req=%b addr=%h expected 0 1 0", halt, mem_req, mem_addr);
        end
    endtask

    task automatic test_reset_mid_stall();
        int s0;
        clear_prog();
        prog[0] = enc_i(10, 0, 3'b000, 10, 7'h13);
        prog[1] = enc_s(64, 10, 0);
        stall_addr = 32'h40;
        stall_n    = 20;
        do_reset();
        s0 = store_cnt;
        run_cycles(10);
        n_chk++; if (tr_req[10] !== 1'b1 || tr_we[10] !== 1'b1 || tr_a0[10] !== 32'd10) begin
            n_fail++; $display("FAIL midrst_pre: got req=%b we=%b a0=%h expected 1 1 0000000a", tr_req[10], tr_we[10], tr_a0[10]);
        end
        do_reset();
        n_chk++; if (store_cnt != s0) begin n_fail++; $display("FAIL midrst_store: got %0d stores expected 0", store_cnt - s0); end
        n_chk++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0) begin
            n_fail++; $display("FAIL midrst_fetch: got req=%b we=%b addr=%h expected 1 0 0", mem_req, mem_we, mem_addr);
        end
        n_chk++; if (a0 !== 32'h0) begin n_fail++; $display("FAIL midrst_a0: got %h expected 0", a0); end
    endtask

    task automatic test_perfcnt();
        clear_prog();
        for (int i = 0; i < 10; i++) prog[i] = enc_i(1, 10, 3'b000, 10, 7'h13);
        do_reset();
        run_cycles(40);
        n_chk++; if (a0 !== 32'd10) begin n_fail++; $display("FAIL perf_a0: got %h expected 0000000a", a0); end
`ifdef MULTICYCLE_PERFCNT_EN
        n_chk++; if (instret_cnt !== 32'd10) begin n_fail++; $display("FAIL perf_instret: got %0d expected 10", instret_cnt); end
        n_chk++; if (cycle_cnt !== 32'd40) begin n_fail++; $display("FAIL perf_cycle: got %0d expected 40", cycle_cnt); end
`else
        n_chk++; if (instret_cnt !== 32'd0) begin n_fail++; $display("FAIL perf_instret_tied: got %0d expected 0", instret_cnt); end
        n_chk++; if (cycle_cnt !== 32'd0) begin n_fail++; $display("FAIL perf_cycle_tied: got %0d expected 0", cycle_cnt); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_prog();
        test_reset();
        test_alu_add();
        test_alu_ops();
        test_mem_stall();
        test_branch();
        test_jal_lui();
        test_halt();
        test_reset_mid_stall();
        test_perfcnt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
